// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared widths and FSM encoding for the I2C command arbiter.
package i2c_cmd_arbiter_pkg;

    localparam int I2C_CTRL_W   = 11;
    localparam int I2C_STATUS_W = 10;
    localparam int I2C_BUSY_BIT = 9;

    typedef enum logic [2:0] {
        ARB_IDLE       = 3'd0,
        ARB_ISSUE      = 3'd1,
        ARB_WAIT_START = 3'd2,
        ARB_WAIT_DONE  = 3'd3,
        ARB_DONE       = 3'd4
    } arb_state_e;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Combinational requester picker: round-robin from 'start' by default,
// lowest-index fixed priority when I2C_ARB_FIXED_PRIO_EN is defined.
module i2c_cmd_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef I2C_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[IDX_W'(k)]) begin
                grant = IDX_W'(k);
                any   = 1'b1;
            end
        end
    end
`else
    int rr_idx;

    // Walk the request vector starting at 'start', wrapping past NUM_REQ-1.
    always_comb begin
        grant  = '0;
        any    = 1'b0;
        rr_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(start) + k;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (!any && req[IDX_W'(rr_idx)]) begin
                grant = IDX_W'(rr_idx);
                any   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one i2c_controller among NUM_REQ requesters, with an optional bus lock.
// Define I2C_ARB_FIXED_PRIO_EN for fixed-priority selection instead of round-robin.
module i2c_cmd_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int START_TMO = 15,
    parameter int LOCK_TMO  = 255
) (
    input  logic                          S00_AXI_aclk,
    input  logic                          S00_AXI_aresetn,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*I2C_CTRL_W-1:0] req_ctrl_i,
    input  logic [NUM_REQ-1:0]            req_lock_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [I2C_STATUS_W-1:0]       rsp_status_o,
    output logic                          rsp_err_o,
    output logic                          i2c_cmd_pulse_o,
    output logic [I2C_CTRL_W-1:0]         i2c_ctrl_reg_o,
    input  logic [I2C_STATUS_W-1:0]       i2c_status_reg_i,
    output logic                          arb_busy_o
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int START_W = $clog2(START_TMO + 1);
    localparam int LOCK_W  = $clog2(LOCK_TMO + 1);

    arb_state_e              state, state_next;
    logic [IDX_W-1:0]        grant_q, last_grant, lock_owner, start_idx, pick_idx;
    logic                    pick_any, lock_held, lock_q, busy_seen, start_hit;
    logic [NUM_REQ-1:0]      eligible, grant_onehot;
    logic [I2C_CTRL_W-1:0]   ctrl_q;
    logic [I2C_STATUS_W-1:0] status_q, rsp_status_q;
    logic                    rsp_err_q;
    logic [START_W-1:0]      start_cnt, start_cnt_inc;
    logic [LOCK_W-1:0]       lock_cnt, lock_cnt_inc;

    assign start_idx    = (last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant + IDX_W'(1);
    assign eligible     = lock_held ? (req_valid_i & (NUM_REQ'(1) << lock_owner)) : req_valid_i;
    assign grant_onehot = NUM_REQ'(1) << grant_q;
    assign busy_seen    = status_q[I2C_BUSY_BIT];

    assign start_cnt_inc = (start_cnt == START_W'(START_TMO)) ? start_cnt : start_cnt + START_W'(1);
    assign lock_cnt_inc  = (lock_cnt == LOCK_W'(LOCK_TMO)) ? lock_cnt : lock_cnt + LOCK_W'(1);
    assign start_hit     = (start_cnt_inc == START_W'(START_TMO));

    assign rsp_status_o = rsp_status_q;
    assign rsp_err_o    = rsp_err_q;

    i2c_cmd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (eligible),
        .start (start_idx),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge S00_AXI_aclk) begin
        if (!S00_AXI_aresetn) state <= ARB_IDLE;
        else                  state <= state_next;
    end

    always_comb begin
        state_next      = state;
        i2c_cmd_pulse_o = 1'b0;
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        i2c_ctrl_reg_o  = '0;
        arb_busy_o      = (state != ARB_IDLE);
        if (state != ARB_IDLE) i2c_ctrl_reg_o = ctrl_q;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) state_next = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                i2c_cmd_pulse_o = 1'b1;
                req_ready_o     = grant_onehot;
                state_next      = ARB_WAIT_START;
            end
            ARB_WAIT_START: begin
                if (busy_seen)      state_next = ARB_WAIT_DONE;
                else if (start_hit) state_next = ARB_DONE;
            end
            ARB_WAIT_DONE: begin
                if (!busy_seen) state_next = ARB_DONE;
            end
            ARB_DONE: begin
                rsp_valid_o = grant_onehot;
                state_next  = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Controller status is registered once; busy decisions and the captured
    // response both use this copy, giving the two-cycle busy-fall to rsp latency.
    always_ff @(posedge S00_AXI_aclk) begin
        if (!S00_AXI_aresetn) begin
            grant_q      <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            lock_owner   <= '0;
            lock_held    <= 1'b0;
            lock_q       <= 1'b0;
            ctrl_q       <= '0;
            status_q     <= '0;
            rsp_status_q <= '0;
            rsp_err_q    <= 1'b0;
            start_cnt    <= '0;
            lock_cnt     <= '0;
        end else begin
            status_q <= i2c_status_reg_i;
            unique case (state)
                ARB_IDLE: begin
                    // A valid lock owner is always picked, which also clears its idle count.
                    if (pick_any) begin
                        grant_q  <= pick_idx;
                        ctrl_q   <= req_ctrl_i[int'(pick_idx)*I2C_CTRL_W +: I2C_CTRL_W];
                        lock_q   <= req_lock_i[pick_idx];
                        lock_cnt <= '0;
                    end else if (lock_held) begin
                        lock_cnt <= lock_cnt_inc;
                        if (lock_cnt_inc == LOCK_W'(LOCK_TMO)) lock_held <= 1'b0;
                    end
                end
                ARB_ISSUE: start_cnt <= '0;
                ARB_WAIT_START: begin
                    start_cnt <= start_cnt_inc;
                    if (!busy_seen && start_hit) begin
                        rsp_status_q <= status_q;
                        rsp_err_q    <= 1'b1;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (!busy_seen) begin
                        rsp_status_q <= status_q;
                        rsp_err_q    <= 1'b0;
                    end
                end
                ARB_DONE: begin
                    last_grant <= grant_q;
                    lock_owner <= grant_q;
                    lock_held  <= lock_q && !rsp_err_q;
                    lock_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a small i2c_controller model
// (busy rises two cycles after the command pulse and stays high model_n cycles).
module tb_i2c_cmd_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 11;

    logic             clk     = 1'b0;
    logic             aresetn = 1'b0;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_lock  = '0;
    logic [NREQ*CW-1:0] req_ctrl = '0;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ-1:0]  rsp_valid;
    logic [9:0]       rsp_status;
    logic             rsp_err;
    logic             cmd_pulse;
    logic [CW-1:0]    ctrl_reg;
    logic [9:0]       status;
    logic             arb_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic       model_armed;
    logic       model_busy;
    int         model_left;
    int         model_n    = 3;
    logic       model_dead = 1'b0;
    logic [8:0] model_data = 9'h0A5;

    int rr_exp [5];

    always #5 clk = ~clk;

    assign status = {model_busy, model_data};

    i2c_cmd_arbiter dut (
        .S00_AXI_aclk     (clk),
        .S00_AXI_aresetn  (aresetn),
        .req_valid_i      (req_valid),
        .req_ctrl_i       (req_ctrl),
        .req_lock_i       (req_lock),
        .req_ready_o      (req_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_status_o     (rsp_status),
        .rsp_err_o        (rsp_err),
        .i2c_cmd_pulse_o  (cmd_pulse),
        .i2c_ctrl_reg_o   (ctrl_reg),
        .i2c_status_reg_i (status),
        .arb_busy_o       (arb_busy)
    );

    // Controller model: pulse seen at edge e -> busy from edge e+2 for model_n cycles.
    always @(posedge clk) begin
        if (!aresetn) begin
            model_armed <= 1'b0;
            model_busy  <= 1'b0;
            model_left  <= 0;
        end else begin
            model_armed <= cmd_pulse && !model_dead;
            if (model_armed) begin
                model_busy <= 1'b1;
                model_left <= model_n;
            end else if (model_busy) begin
                if (model_left <= 1) model_busy <= 1'b0;
                model_left <= model_left - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic lock, input logic [CW-1:0] ctrl);
        req_valid[idx]          = valid;
        req_lock[idx]           = lock;
        req_ctrl[idx*CW +: CW]  = ctrl;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pulse"},      32'(cmd_pulse),  32'h0);
        checkOutput({tag, ".ready"},      32'(req_ready),  32'h0);
        checkOutput({tag, ".rsp_valid"},  32'(rsp_valid),  32'h0);
        checkOutput({tag, ".rsp_status"}, 32'(rsp_status), 32'h0);
        checkOutput({tag, ".rsp_err"},    32'(rsp_err),    32'h0);
        checkOutput({tag, ".ctrl_reg"},   32'(ctrl_reg),   32'h0);
        checkOutput({tag, ".arb_busy"},   32'(arb_busy),   32'h0);
    endtask

    // Waits (bounded) for the command pulse, then for the response pulse, and
    // compares timing, grant, ctrl word stability and response contents.
    task automatic serveCmd(input string tag, input bit drop, input int max_wait,
                            input int exp_pulse_wait, input logic [3:0] exp_ready,
                            input logic [CW-1:0] exp_ctrl, input int exp_rsp_wait,
                            input int exp_gap, input logic exp_err, input logic [9:0] exp_status);
        int pulse_wait, rsp_wait, fall_c, extra, ctrl_bad, gap;
        logic [3:0]    ready_vec, rsp_vec;
        logic [CW-1:0] ctrl_seen;
        logic          prev_busy;
        pulse_wait = -1; rsp_wait = -1; fall_c = -1; extra = 0; ctrl_bad = 0;
        ready_vec = '0; rsp_vec = '0; ctrl_seen = '0;
        for (int c = 1; c <= max_wait; c++) begin
            @(negedge clk);
            if (cmd_pulse) begin
                pulse_wait = c;
                ready_vec  = req_ready;
                ctrl_seen  = ctrl_reg;
                break;
            end
        end
        if (drop) req_valid = req_valid & ~req_ready;
        prev_busy = status[9];
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (cmd_pulse) extra++;
            if (ctrl_reg !== ctrl_seen) ctrl_bad++;
            if (prev_busy && !status[9]) fall_c = c;
            prev_busy = status[9];
            if (rsp_valid != '0) begin
                rsp_vec  = rsp_valid;
                rsp_wait = c;
                break;
            end
        end
        gap = (fall_c >= 0 && rsp_wait >= 0) ? rsp_wait - fall_c : -1;
        checkOutput({tag, ".pulse_wait"},  32'(pulse_wait), 32'(exp_pulse_wait));
        checkOutput({tag, ".ready"},       32'(ready_vec),  32'(exp_ready));
        checkOutput({tag, ".ctrl"},        32'(ctrl_seen),  32'(exp_ctrl));
        checkOutput({tag, ".ctrl_stable"}, 32'(ctrl_bad),   32'h0);
        checkOutput({tag, ".extra_pulse"}, 32'(extra),      32'h0);
        checkOutput({tag, ".rsp_valid"},   32'(rsp_vec),    32'(exp_ready));
        checkOutput({tag, ".rsp_wait"},    32'(rsp_wait),   32'(exp_rsp_wait));
        checkOutput({tag, ".fall_to_rsp"}, 32'(gap),        32'(exp_gap));
        checkOutput({tag, ".rsp_err"},     32'(rsp_err),    32'(exp_err));
        checkOutput({tag, ".rsp_status"},  32'(rsp_status), 32'(exp_status));
    endtask

    initial begin
        int w;
`ifdef I2C_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        $display("[TB] start");

        // Reset state
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        // Single command from requester 0, long busy
        model_n = 20; model_data = 9'h0A5;
        aresetn = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 11'h5A3);
        serveCmd("single", 1'b1, 20, 1, 4'b0001, 11'h5A3, 24, 2, 1'b0, 10'h0A5);
        @(negedge clk);
        checkOutput("single.idle_ctrl", 32'(ctrl_reg), 32'h0);
        checkOutput("single.idle_busy", 32'(arb_busy), 32'h0);

        // All four requesters held valid from reset
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        model_n = 3; model_data = 9'h033;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b0, 11'h100 + 11'(i));
        for (int i = 0; i < 5; i++)
            serveCmd($sformatf("rr%0d", i), 1'b0, 20, (i == 0) ? 1 : 2, 4'(1 << rr_exp[i]),
                     11'h100 + 11'(rr_exp[i]), 7, 2, 1'b0, 10'h033);
        req_valid = '0;

        // Locked requester 1 is served twice before pending requester 2
        applyStimulus(1, 1'b1, 1'b1, 11'h111);
        applyStimulus(2, 1'b1, 1'b0, 11'h222);
        serveCmd("lock_a", 1'b1, 20, 2, 4'b0010, 11'h111, 7, 2, 1'b0, 10'h033);
        applyStimulus(1, 1'b1, 1'b0, 11'h112);
        serveCmd("lock_b", 1'b1, 20, 2, 4'b0010, 11'h112, 7, 2, 1'b0, 10'h033);
        serveCmd("lock_c", 1'b1, 20, 2, 4'b0100, 11'h222, 7, 2, 1'b0, 10'h033);

        // Lock released after 255 idle cycles; requester 3 issues on cycle 257 after DONE
        applyStimulus(1, 1'b1, 1'b1, 11'h155);
        serveCmd("tmo_lock", 1'b1, 20, 2, 4'b0010, 11'h155, 7, 2, 1'b0, 10'h033);
        applyStimulus(3, 1'b1, 1'b0, 11'h333);
        serveCmd("tmo_release", 1'b1, 300, 257, 4'b1000, 11'h333, 7, 2, 1'b0, 10'h033);

        // Controller never goes busy: error after 15 WAIT_START cycles, no lock taken
        model_dead = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 11'h0F0);
        serveCmd("dead", 1'b1, 20, 2, 4'b0001, 11'h0F0, 16, -1, 1'b1, 10'h033);
        model_dead = 1'b0; model_data = 9'h15A;
        applyStimulus(2, 1'b1, 1'b0, 11'h2A2);
        serveCmd("after_dead", 1'b1, 20, 2, 4'b0100, 11'h2A2, 7, 2, 1'b0, 10'h15A);

        // Reset during WAIT_DONE
        model_n = 20; model_data = 9'h1C4;
        applyStimulus(0, 1'b1, 1'b0, 11'h0AA);
        w = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cmd_pulse) begin w = c; break; end
        end
        checkOutput("mid.pulse_wait", 32'(w), 32'd2);
        req_valid[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (status[9]) break;
        end
        repeat (3) @(negedge clk);
        checkOutput("mid.busy_before", 32'(arb_busy), 32'h1);
        aresetn = 1'b0;
        @(negedge clk);
        checkAllZero("mid_reset");
        @(negedge clk);
        checkOutput("mid.no_rsp", 32'(rsp_valid), 32'h0);
        aresetn = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 11'h3C0);
        serveCmd("post_reset", 1'b1, 20, 1, 4'b0010, 11'h3C0, 24, 2, 1'b0, 10'h1C4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
